adc_level_filter: RTL and testbench

ADC_LEVEL_FILTER -- requirements
Module: adc_level_filter

---
 rtl/adc_pkg.sv | 27 ++
 rtl/adc_window_sum.sv | 45 ++++
 rtl/adc_level_filter.sv | 102 ++++++++++
 tb/tb_adc_level_filter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// adc_pkg: shared constants and types for the ADC level filter.
//   WIN_LOG2   - log2 of the averaging window (4 samples)
//   SUM_W      - running-sum width (8-bit samples summed over the window)
//   LVL_SET_CV - volt_cv at or above which level_hi sets
//   LVL_CLR_CV - volt_cv below which level_hi clears
//   state_e    - warm-up / run state encoding
package adc_pkg;

  localparam int WIN_LOG2 = 2;
  localparam int SUM_W    = 8 + WIN_LOG2;

  localparam logic [8:0] LVL_SET_CV = 9'd400;
  localparam logic [8:0] LVL_CLR_CV = 9'd360;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } state_e;

  // Hysteresis next value: set at/above SET, clear below CLR, else keep.
  function automatic logic lvl_next(input logic [8:0] volt, input logic cur);
    if (volt >= LVL_SET_CV)     return 1'b1;
    else if (volt < LVL_CLR_CV) return 1'b0;
    else                        return cur;
  endfunction

endpackage

// File: rtl/adc_window_sum.sv
// adc_window_sum: circular sample buffer with a running sum.
//   clk, rst   - clock, async active-high reset
//   i_acc      - accept strobe; i_sample is written this cycle
//   i_sample   - 8-bit sample
//   o_avg      - truncated window mean, valid the cycle after i_acc
// The oldest entry always sits at the write pointer, so an accepted sample
// replaces it and the sum is corrected by (new - oldest) in one step.
module adc_window_sum
  import adc_pkg::*;
#(
  parameter int WLOG2 = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_acc,
  input  logic [7:0] i_sample,
  output logic [7:0] o_avg
);

  localparam int WIN = 1 << WLOG2;
  localparam int SW  = 8 + WLOG2;

  logic [WIN-1:0][7:0] r_buf;
  logic [WLOG2-1:0]    r_ptr;
  logic [SW-1:0]       r_sum;
  logic [7:0]          w_old;

  assign w_old = r_buf[r_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf <= '0;
      r_ptr <= '0;
      r_sum <= '0;
    end else if (i_acc) begin
      r_buf[r_ptr] <= i_sample;
      r_ptr        <= r_ptr + 1'b1;
      // Buffer is zeroed on reset, so warm-up subtracts zeros.
      r_sum        <= r_sum - SW'(w_old) + SW'(i_sample);
    end
  end

  assign o_avg = r_sum[SW-1 -: 8];

endmodule

// File: rtl/adc_level_filter.sv
// adc_level_filter: 4-sample moving average of ADC readings with a
// voltage-scaled output and a hysteresis level flag.
//   clk, rst     - clock, async active-high reset
//   sample       - 8-bit ADC conversion result
//   sample_valid - one-cycle sample strobe
//   hold         - drop incoming samples while high
//   avg          - window mean (registered)
//   volt_cv      - avg*2 in 0.01 V units (registered)
//   avg_valid    - one-cycle pulse when avg/volt_cv/level_hi update
//   level_hi     - hysteresis flag on volt_cv
//   warm         - high until the window has been filled once
// Latency: sample accepted in cycle N -> sum in N+1 -> outputs in N+2.
module adc_level_filter
  import adc_pkg::*;
#(
  parameter int WIN_LOG2 = adc_pkg::WIN_LOG2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample,
  input  logic       sample_valid,
  input  logic       hold,
  output logic [7:0] avg,
  output logic [8:0] volt_cv,
  output logic       avg_valid,
  output logic       level_hi,
  output logic       warm
);

  state_e              r_state, w_state_nxt;
  logic [WIN_LOG2-1:0] r_cnt;
  logic [1:0]          r_vld_pipe;
  logic                w_acc;
  logic                w_emit;
  logic [7:0]          w_avg;
  logic [8:0]          w_volt;
  logic [7:0]          r_avg;
  logic [8:0]          r_volt;
  logic                r_lvl;

  // Hold only gates acceptance; anything already in the pipe completes.
  assign w_acc = sample_valid & ~hold;

  adc_window_sum #(.WLOG2(WIN_LOG2)) u_win (
    .clk      (clk),
    .rst      (rst),
    .i_acc    (w_acc),
    .i_sample (sample),
    .o_avg    (w_avg)
  );

  // ---- FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= WARMUP;
    else     r_state <= w_state_nxt;
  end

  // ---- FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == WARMUP && w_acc && r_cnt == '1) w_state_nxt = RUN;
  end

  // ---- FSM: outputs
  always_comb begin
    warm   = (r_state == WARMUP);
    // The sample that completes the first window already gets a result.
    w_emit = w_acc && (r_state == RUN || r_cnt == '1);
  end

  // Accepted-sample counter, only meaningful during warm-up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             r_cnt <= '0;
    else if (r_state == WARMUP && w_acc) r_cnt <= r_cnt + 1'b1;
  end

  // [0]: sum updated this cycle; [1]: outputs updated this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_vld_pipe <= '0;
    else     r_vld_pipe <= {r_vld_pipe[0], w_emit};
  end

  assign w_volt = {w_avg, 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_avg  <= '0;
      r_volt <= '0;
      r_lvl  <= 1'b0;
    end else if (r_vld_pipe[0]) begin
      r_avg  <= w_avg;
      r_volt <= w_volt;
      r_lvl  <= lvl_next(w_volt, r_lvl);
    end
  end

  assign avg       = r_avg;
  assign volt_cv   = r_volt;
  assign level_hi  = r_lvl;
  assign avg_valid = r_vld_pipe[1];

endmodule

// File: tb/tb_adc_level_filter.sv
module tb_adc_level_filter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sample = '0;
  logic       sample_valid = 1'b0;
  logic       hold = 1'b0;
  logic [7:0] avg;
  logic [8:0] volt_cv;
  logic       avg_valid;
  logic       level_hi;
  logic       warm;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  int q_cyc[$];
  int q_avg[$];
  int q_volt[$];
  int q_lvl[$];

  adc_level_filter dut (
    .clk          (clk),
    .rst          (rst),
    .sample       (sample),
    .sample_valid (sample_valid),
    .hold         (hold),
    .avg          (avg),
    .volt_cv      (volt_cv),
    .avg_valid    (avg_valid),
    .level_hi     (level_hi),
    .warm         (warm)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every result pulse away from the active edge.
  always @(negedge clk) begin
    if (avg_valid) begin
      q_cyc.push_back(cyc);
      q_avg.push_back(int'(avg));
      q_volt.push_back(int'(volt_cv));
      q_lvl.push_back(int'(level_hi));
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic qclr();
    q_cyc.delete(); q_avg.delete(); q_volt.delete(); q_lvl.delete();
  endtask

  // Present one sample for the next edge; dc = cycle it is presented in.
  task automatic push(input int s, input bit h, output int dc);
    @(posedge clk); #1;
    sample = 8'(s); sample_valid = 1'b1; hold = h;
    dc = cyc;
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    sample_valid = 1'b0; hold = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    sample_valid = 1'b0; hold = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int dc;
    int dcs[$];
    int exp_avg[5];
    int exp_lvl[5];
    exp_avg = '{200, 194, 189, 184, 179};
    exp_lvl = '{1, 1, 1, 1, 0};

    // Reset values
    repeat (2) @(posedge clk); #1;
    chk("rst_avg", avg, 0);
    chk("rst_volt", volt_cv, 0);
    chk("rst_vld", avg_valid, 0);
    chk("rst_lvl", level_hi, 0);
    chk("rst_warm", warm, 1);
    rst = 1'b0;

    // Four 100s back-to-back
    qclr();
    for (int i = 0; i < 4; i++) begin
      push(100, 0, dc);
      if (i == 3) chk("t1_warm_pre", warm, 1);
    end
    idle(4);
    chk("t1_n", q_cyc.size(), 1);
    if (q_cyc.size() == 1) begin
      chk("t1_lat", q_cyc[0], dc + 2);
      chk("t1_avg", q_avg[0], 100);
      chk("t1_volt", q_volt[0], 200);
      chk("t1_lvl", q_lvl[0], 0);
    end
    chk("t1_warm", warm, 0);

    // Hysteresis: 200 x4 then 179 x4
    do_reset();
    qclr();
    for (int i = 0; i < 4; i++) push(200, 0, dc);
    for (int i = 0; i < 4; i++) push(179, 0, dc);
    idle(4);
    chk("t2_n", q_cyc.size(), 5);
    if (q_cyc.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("t2_avg%0d", i), q_avg[i], exp_avg[i]);
        chk($sformatf("t2_volt%0d", i), q_volt[i], 2 * exp_avg[i]);
        chk($sformatf("t2_lvl%0d", i), q_lvl[i], exp_lvl[i]);
        chk($sformatf("t2_cyc%0d", i), q_cyc[i], q_cyc[0] + i);
      end
    end

    // Truncation: 1,2,2,2 -> sum 7 -> avg 1
    do_reset();
    qclr();
    push(1, 0, dc); push(2, 0, dc); push(2, 0, dc); push(2, 0, dc);
    idle(4);
    chk("t3_n", q_cyc.size(), 1);
    if (q_cyc.size() == 1) begin
      chk("t3_avg", q_avg[0], 1);
      chk("t3_volt", q_volt[0], 2);
    end

    // Hold drops a sample without side effects
    do_reset();
    for (int i = 0; i < 4; i++) push(200, 0, dc);
    idle(4);
    qclr();
    push(50, 1, dc);
    idle(4);
    chk("t4_hold_n", q_cyc.size(), 0);
    chk("t4_hold_avg", avg, 200);
    chk("t4_hold_volt", volt_cv, 400);
    chk("t4_hold_lvl", level_hi, 1);
    // window still 200 x4: replacing one 200 by 0 -> 600/4
    push(0, 0, dc);
    idle(4);
    chk("t4_next_n", q_cyc.size(), 1);
    if (q_cyc.size() == 1) begin
      chk("t4_next_avg", q_avg[0], 150);
      chk("t4_next_volt", q_volt[0], 300);
      chk("t4_next_lvl", q_lvl[0], 0);
    end
    // hold rising right behind an accepted sample: in-flight one completes
    qclr();
    push(100, 0, dc);
    push(77, 1, dc);
    idle(4);
    chk("t4_inflt_n", q_cyc.size(), 1);
    if (q_cyc.size() == 1) chk("t4_inflt_avg", q_avg[0], 125);

    // Reset mid-window
    push(10, 0, dc); push(20, 0, dc);
    do_reset();
    #1;
    chk("t5_rst_avg", avg, 0);
    chk("t5_rst_warm", warm, 1);
    qclr();
    for (int i = 0; i < 4; i++) begin
      push(255, 0, dc);
      if (i == 3) chk("t5_warm_pre", warm, 1);
    end
    idle(4);
    chk("t5_n", q_cyc.size(), 1);
    if (q_cyc.size() == 1) begin
      chk("t5_lat", q_cyc[0], dc + 2);
      chk("t5_avg", q_avg[0], 255);
      chk("t5_volt", q_volt[0], 510);
      chk("t5_lvl", q_lvl[0], 1);
    end
    chk("t5_warm", warm, 0);

    // Ten back-to-back samples in RUN
    qclr();
    dcs.delete();
    for (int i = 0; i < 10; i++) begin
      push(i * 10, 0, dc);
      dcs.push_back(dc);
    end
    idle(4);
    chk("t6_n", q_cyc.size(), 10);
    if (q_cyc.size() == 10) begin
      for (int i = 0; i < 10; i++)
        chk($sformatf("t6_lat%0d", i), q_cyc[i], dcs[i] + 2);
      chk("t6_last_avg", q_avg[9], 75);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
